// File: rtl/bcd_to_bin.sv
// Sequential MSD-first BCD-to-binary converter for the time-set path.
// Optional final-value range check against MAX_VALUE: define BCD_TO_BIN_RANGE_CHECK_EN.
module bcd_to_bin #(
  parameter int DIGITS    = 2,
  parameter int OUT_W     = 6,
  parameter int MAX_VALUE = 59
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [3:0]       i_digit,
  input  logic             i_digit_valid,
  output logic             o_digit_ready,
  output logic [OUT_W-1:0] o_bin,
  output logic             o_valid,
  output logic             o_error,
  output logic             o_busy
);

  localparam int ACC_W = OUT_W + 4;
  localparam int CNT_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [OUT_W-1:0] r_bin;

  logic [ACC_W-1:0] w_next_acc;
  logic             w_xfer;
  logic             w_last;
  logic             w_bad_digit;
  logic             w_overflow;
  logic             w_range_bad;
  logic             w_load_bin;

  // Handshake: a digit transfers on a rising edge where i_digit_valid and
  // o_digit_ready are both high and i_start is low; i_digit must be stable then.
  always_comb begin
    w_next_acc  = (r_acc << 3) + (r_acc << 1) + {{OUT_W{1'b0}}, i_digit};
    w_xfer      = (r_state == ST_COLLECT) && i_digit_valid && !i_start;
    w_last      = (r_count == CNT_W'(DIGITS - 1));
    w_bad_digit = (i_digit > 4'd9);
    w_overflow  = (w_next_acc[ACC_W-1:OUT_W] != 4'd0);
`ifdef BCD_TO_BIN_RANGE_CHECK_EN
    w_range_bad = (w_next_acc > ACC_W'(MAX_VALUE));
`else
    w_range_bad = 1'b0;
`endif
    w_load_bin  = w_xfer && w_last && !w_bad_digit && !w_overflow && !w_range_bad;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    w_next_state = ST_IDLE;
      ST_COLLECT: begin
        if (w_xfer) begin
          if (w_bad_digit || w_overflow) begin
            w_next_state = ST_ERROR;
          end else if (w_last) begin
            w_next_state = w_range_bad ? ST_ERROR : ST_DONE;
          end
        end
      end
      ST_DONE:    w_next_state = ST_IDLE;
      ST_ERROR:   w_next_state = ST_ERROR;
      default:    w_next_state = ST_IDLE;
    endcase
    // Start overrides everything below reset, including the DONE->IDLE return.
    if (i_start) begin
      w_next_state = ST_COLLECT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_bin   <= '0;
    end else begin
      r_state <= w_next_state;
      if (i_start) begin
        r_acc   <= '0;
        r_count <= '0;
      end else if (w_xfer) begin
        r_acc   <= w_next_acc;
        r_count <= r_count + 1'b1;
      end
      if (w_load_bin) begin
        r_bin <= w_next_acc[OUT_W-1:0];
      end
    end
  end

  assign o_digit_ready = (r_state == ST_COLLECT);
  assign o_busy        = (r_state == ST_COLLECT);
  assign o_valid       = (r_state == ST_DONE);
  assign o_error       = (r_state == ST_ERROR);
  assign o_bin         = r_bin;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: driver tasks push expected outcomes into a
// queue; a monitor pops on every o_valid strobe or o_error rise and compares.
module tb_bcd_to_bin;

  localparam int OUT_W = 6;
  localparam int W     = OUT_W + 1;

  logic             clk;
  logic             i_reset;
  logic             i_start;
  logic [3:0]       i_digit;
  logic             i_digit_valid;
  logic             o_digit_ready;
  logic [OUT_W-1:0] o_bin;
  logic             o_valid;
  logic             o_error;
  logic             o_busy;

  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_errors;
  logic [OUT_W-1:0] last_bin;

  bcd_to_bin #(.DIGITS(2), .OUT_W(OUT_W), .MAX_VALUE(59)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_digit       (i_digit),
    .i_digit_valid (i_digit_valid),
    .o_digit_ready (o_digit_ready),
    .o_bin         (o_bin),
    .o_valid       (o_valid),
    .o_error       (o_error),
    .o_busy        (o_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] d);
    i_digit       = d;
    i_digit_valid = 1'b1;
    tick();
    i_digit_valid = 1'b0;
  endtask

  // Expected entry: {error_flag, o_bin}. Error outcomes keep the previous o_bin.
  task automatic expect_ok(input int value);
    exp_q.push_back({1'b0, OUT_W'(value)});
    last_bin = OUT_W'(value);
  endtask

  task automatic expect_err();
    exp_q.push_back({1'b1, last_bin});
  endtask

  task automatic conv2(input logic [3:0] d0, input logic [3:0] d1, input bit ok);
    do_start();
    send_digit(d0);
    send_digit(d1);
    check("strobe_latency", int'(o_valid), int'(ok));
    check("error_latency", int'(o_error), int'(!ok));
  endtask

  // scoreboard monitor
  logic prev_error;
  logic prev_valid;
  initial begin
    prev_error = 1'b0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid && prev_valid) begin
        check("strobe_width", 2, 1);
      end
      if (o_valid || (o_error && !prev_error)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", int'({o_error, o_bin}), -1);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("result_err", int'(o_error), int'(e[W-1]));
          check("result_bin", int'(o_bin), int'(e[OUT_W-1:0]));
        end
      end
      prev_error = o_error;
      prev_valid = o_valid;
    end
  end

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    last_bin      = '0;
    i_reset       = 1'b1;
    i_start       = 1'b0;
    i_digit       = 4'd0;
    i_digit_valid = 1'b0;
    repeat (3) tick();
    i_reset = 1'b0;
    tick();
    check("rst_bin", int'(o_bin), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_error", int'(o_error), 0);
    check("rst_ready", int'(o_digit_ready), 0);
    check("rst_busy", int'(o_busy), 0);

    // 4,7 -> 47
    do_start();
    check("collect_ready", int'(o_digit_ready), 1);
    check("collect_busy", int'(o_busy), 1);
    expect_ok(47);
    send_digit(4'd4);
    send_digit(4'd7);
    check("strobe_latency", int'(o_valid), 1);
    check("bin_47", int'(o_bin), 47);
    tick();
    check("strobe_drop", int'(o_valid), 0);
    check("busy_after", int'(o_busy), 0);
    check("ready_idle", int'(o_digit_ready), 0);

    // invalid digit, then recovery
    expect_err();
    conv2(4'd1, 4'hA, 1'b0);
    repeat (2) tick();
    check("error_held", int'(o_error), 1);
    check("error_ready", int'(o_digit_ready), 0);
    do_start();
    check("error_clear", int'(o_error), 0);
    expect_ok(9);
    send_digit(4'd0);
    send_digit(4'd9);
    check("bin_9", int'(o_bin), 9);
    tick();

    // 63: out of range only when the range check is compiled in
`ifdef BCD_TO_BIN_RANGE_CHECK_EN
    expect_err();
    conv2(4'd6, 4'd3, 1'b0);
`else
    expect_ok(63);
    conv2(4'd6, 4'd3, 1'b1);
`endif
    tick();

    // 70 overflows 6 bits in either build
    expect_err();
    conv2(4'd7, 4'd0, 1'b0);
    tick();

    // restart discards a partially entered value
    do_start();
    send_digit(4'd5);
    expect_ok(23);
    do_start();
    send_digit(4'd2);
    send_digit(4'd3);
    check("strobe_restart", int'(o_valid), 1);
    // start while in DONE: strobe already shown, go straight to COLLECT
    do_start();
    check("done_start_busy", int'(o_busy), 1);
    expect_ok(45);
    send_digit(4'd4);
    send_digit(4'd5);
    tick();

    // valid gaps between digits
    for (int gap = 0; gap <= 3; gap++) begin
      do_start();
      send_digit(4'd3);
      repeat (gap) begin
        i_digit = 4'd8;
        tick();
      end
      check("gap_busy", int'(o_busy), 1);
      expect_ok(31);
      send_digit(4'd1);
      check("gap_strobe", int'(o_valid), 1);
      tick();
    end

    // reset mid-entry
    do_start();
    send_digit(4'd8);
    i_reset = 1'b1;
    tick();
    check("midrst_bin", int'(o_bin), 0);
    check("midrst_valid", int'(o_valid), 0);
    check("midrst_error", int'(o_error), 0);
    check("midrst_ready", int'(o_digit_ready), 0);
    check("midrst_busy", int'(o_busy), 0);
    i_reset = 1'b0;
    last_bin = '0;

    begin
      int budget;
      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
        tick();
        budget--;
      end
      check("queue_drained", exp_q.size(), 0);
    end
    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
